// File: rtl/riscv_32i_config_pkg.sv
// Shared data-memory configuration for the RV32I core: memory geometry,
// arbiter FSM states and the requester-index type.
package riscv_32i_config_pkg;

    localparam int          DATA_MEM_DEPTH             = 1024;
    localparam logic [31:0] DATA_MEM_LAST_ADDR         = 32'(DATA_MEM_DEPTH * 4 - 1);
    localparam logic [31:0] DATA_MEM_LAST_ALIGNED_ADDR = DATA_MEM_LAST_ADDR - 32'd3;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Two requesters: 0 = core LSU, 1 = loader/debug.
    typedef logic [0:0] req_idx_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side and memory-side signals of the data memory arbiter.
// slave = arbiter view, master = requesters plus memory model.
interface data_mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int MEM_AW  = 10
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0][31:0]  addr;
    logic [NUM_REQ-1:0][31:0]  wdata;
    logic [NUM_REQ-1:0][3:0]   wstrb;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [NUM_REQ-1:0][31:0]  rdata;
    logic [NUM_REQ-1:0]        err;

    logic                      mem_en;
    logic                      mem_we;
    logic [MEM_AW-1:0]         mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_wstrb;
    logic [31:0]               mem_rdata;

    modport slave (
        input  req, we, lock, addr, wdata, wstrb, mem_rdata,
        output gnt, rvalid, rdata, err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req, we, lock, addr, wdata, wstrb, mem_rdata,
        input  gnt, rvalid, rdata, err,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/data_mem_arbiter_addr_check.sv
// Combinational legality check for one data-memory access: word aligned,
// inside the memory, and writes must enable at least one byte.
module data_mem_addr_check
    import riscv_32i_config_pkg::*;
#(
    parameter logic [31:0] LAST_ALIGNED = DATA_MEM_LAST_ALIGNED_ADDR
) (
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  wstrb,
    output logic        legal
);
    assign legal = (addr[1:0] == 2'b00) && (addr <= LAST_ALIGNED)
                && !(we && (wstrb == 4'b0000));
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous data memory.
// Grants combinationally, responds exactly one cycle later; supports bus locking.
module data_mem_arbiter
    import riscv_32i_config_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MEM_DEPTH = DATA_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    arb_state_e state_q, state_d;
    req_idx_t   owner_q, owner_d;
    req_idx_t   last_q,  last_d;
    logic       resp_vld_q, resp_vld_d;
    req_idx_t   resp_idx_q, resp_idx_d;
    logic       resp_err_q, resp_err_d;
    logic       resp_rd_q,  resp_rd_d;

    logic        gnt_any;
    req_idx_t    gnt_idx;
    logic        legal;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [3:0]  sel_wstrb;

    logic [NUM_REQ-1:0]       gnt_v;
    logic [NUM_REQ-1:0]       rvalid_v;
    logic [NUM_REQ-1:0]       err_v;
    logic [NUM_REQ-1:0][31:0] rdata_v;

    // Nothing is granted while reset is held, so no transfer can start then.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (rst_n) begin
            if (state_q == ST_LOCKED) begin
                gnt_any = bus.req[owner_q];
                gnt_idx = owner_q;
            end else if (bus.req[0] && bus.req[1]) begin
                gnt_any = 1'b1;
                gnt_idx = ~last_q;
            end else if (bus.req[0]) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b0;
            end else if (bus.req[1]) begin
                gnt_any = 1'b1;
                gnt_idx = 1'b1;
            end
        end
    end

    assign sel_addr  = bus.addr[gnt_idx];
    assign sel_we    = bus.we[gnt_idx];
    assign sel_wstrb = bus.wstrb[gnt_idx];

    data_mem_addr_check #(
        .LAST_ALIGNED (32'(MEM_DEPTH * 4 - 4))
    ) u_addr_check (
        .addr  (sel_addr),
        .we    (sel_we),
        .wstrb (sel_wstrb),
        .legal (legal)
    );

    assign bus.mem_en    = gnt_any && legal;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr[AW+1:2];
    assign bus.mem_wdata = bus.wdata[gnt_idx];
    assign bus.mem_wstrb = sel_wstrb;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        resp_vld_d = gnt_any;
        resp_idx_d = gnt_idx;
        resp_err_d = !legal;
        resp_rd_d  = legal && !sel_we;
        if (gnt_any) begin
            last_d = gnt_idx;
            // Illegal requests move the lock state exactly like legal ones.
            case (state_q)
                ST_ARB: begin
                    if (bus.lock[gnt_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
                ST_LOCKED: begin
                    if (!bus.lock[gnt_idx]) state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            owner_q    <= '0;
            last_q     <= req_idx_t'(1);
            resp_vld_q <= 1'b0;
            resp_idx_q <= '0;
            resp_err_q <= 1'b0;
            resp_rd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            resp_vld_q <= resp_vld_d;
            resp_idx_q <= resp_idx_d;
            resp_err_q <= resp_err_d;
            resp_rd_q  <= resp_rd_d;
        end
    end

    // Response gated by rst_n so a grant just before reset never answers.
    always_comb begin
        gnt_v    = '0;
        rvalid_v = '0;
        err_v    = '0;
        rdata_v  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == req_idx_t'(i))) gnt_v[i] = 1'b1;
            if (rst_n && resp_vld_q && (resp_idx_q == req_idx_t'(i))) begin
                rvalid_v[i] = 1'b1;
                err_v[i]    = resp_err_q;
                if (resp_rd_q) rdata_v[i] = bus.mem_rdata;
            end
        end
    end

    assign bus.gnt    = gnt_v;
    assign bus.rvalid = rvalid_v;
    assign bus.err    = err_v;
    assign bus.rdata  = rdata_v;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration, locking and memory.
module tb_data_mem_arbiter;

    typedef struct {
        int unsigned gap;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } item_t;

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic clk;
    logic rst_n;

    data_mem_arbiter_if #(.NUM_REQ(2), .MEM_AW(10)) bus ();

    data_mem_arbiter #(.NUM_REQ(2), .MEM_DEPTH(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    item_t q0[$];
    item_t q1[$];
    item_t cur[2];
    bit    active[2];
    resp_t expq[$];

    int   m_last   = 1;
    bit   m_locked = 0;
    int   m_owner  = 0;

    logic [31:0] tb_mem [int];
    logic [31:0] shadow [int];

    function automatic logic [31:0] init_val(int w);
        return (32'(w) * 32'h0001_0003) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(int w);
        return tb_mem.exists(w) ? tb_mem[w] : init_val(w);
    endfunction

    function automatic logic [31:0] sh_rd(int w);
        return shadow.exists(w) ? shadow[w] : init_val(w);
    endfunction

    function automatic item_t mk(int unsigned gap, logic we, logic lock,
                                 logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb);
        item_t it;
        it.gap = gap; it.we = we; it.lock = lock;
        it.addr = addr; it.wdata = wdata; it.wstrb = wstrb;
        return it;
    endfunction

    // Round-robin: search starting after the last winner; a lock restricts to its owner.
    function automatic int predict(logic [1:0] r);
        if (m_locked) return r[m_owner] ? m_owner : -1;
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (m_last + k) % 2;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit fetch(int i, output item_t it);
        fetch = 1'b0;
        it = mk(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (i == 0) begin
            if (q0.size() > 0) begin
                if (q0[0].gap > 0) q0[0].gap = q0[0].gap - 1;
                else begin it = q0.pop_front(); fetch = 1'b1; end
            end
        end else begin
            if (q1.size() > 0) begin
                if (q1[0].gap > 0) q1[0].gap = q1[0].gap - 1;
                else begin it = q1.pop_front(); fetch = 1'b1; end
            end
        end
    endfunction

    // Entered and left at posedge+1; holds each request until its gnt is seen.
    task automatic run_phase();
        int         cyc;
        logic [1:0] g;
        item_t      it;
        cyc = 0;
        forever begin
            for (int i = 0; i < 2; i++)
                if (!active[i] && fetch(i, it)) begin
                    cur[i]    = it;
                    active[i] = 1'b1;
                end
            if (!active[0] && !active[1] && q0.size() == 0 && q1.size() == 0) break;
            for (int i = 0; i < 2; i++) begin
                bus.req[i]   = active[i];
                bus.we[i]    = cur[i].we;
                bus.lock[i]  = cur[i].lock;
                bus.addr[i]  = cur[i].addr;
                bus.wdata[i] = cur[i].wdata;
                bus.wstrb[i] = cur[i].wstrb;
            end
            @(negedge clk);
            g = bus.gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) if (active[i] && g[i]) active[i] = 1'b0;
            cyc++;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL driver_timeout actual=%0d cycles required=<=3000", cyc);
                active[0] = 1'b0; active[1] = 1'b0;
                q0.delete(); q1.delete();
                break;
            end
        end
        bus.req = '0;
    endtask

    function automatic item_t rand_item(bit last);
        int unsigned r;
        logic [31:0] a;
        r = $urandom % 10;
        if (r == 0)      a = (($urandom % 1024) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'h1000 + (($urandom % 64) << 2);
        else if (r == 2) a = 32'hFFC;
        else             a = ($urandom % 64) << 2;
        return mk(($urandom % 4 == 0) ? $urandom % 3 : 0, 1'($urandom % 2),
                  last ? 1'b0 : 1'($urandom % 6 == 0), a, $urandom, 4'($urandom % 16));
    endfunction

    // Synchronous memory model: sample the request between edges, present read data after the edge.
    initial begin
        logic        en, wr, upd;
        int          w;
        logic [31:0] nxt;
        bus.mem_rdata = '0;
        nxt = '0;
        forever begin
            @(negedge clk);
            en  = bus.mem_en;
            wr  = bus.mem_we;
            w   = int'(bus.mem_addr);
            upd = 1'b0;
            if (en === 1'b1) begin
                if (wr) tb_mem[w] = merge(mem_rd(w), bus.mem_wdata, bus.mem_wstrb);
                else begin nxt = mem_rd(w); upd = 1'b1; end
            end
            @(posedge clk);
            if (upd) bus.mem_rdata = nxt;
        end
    end

    // Monitor / scoreboard.
    initial begin
        resp_t       e;
        int          w;
        int          wi;
        logic        leg;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt",    32'(bus.gnt),    32'h0);
                chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
                chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
                expq.delete();
                m_last = 1; m_locked = 0; m_owner = 0;
            end else begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("rvalid", 32'(bus.rvalid), 32'(1) << e.idx);
                    chk("err",    32'(bus.err[e.idx]), 32'(e.err));
                    chk("rdata",  bus.rdata[e.idx], e.rdata);
                end else begin
                    chk("rvalid_idle", 32'(bus.rvalid), 32'h0);
                end
                w = predict(bus.req);
                chk("gnt", 32'(bus.gnt), (w < 0) ? 32'h0 : (32'(1) << w));
                if (w >= 0) begin
                    a   = bus.addr[w];
                    leg = (a % 4 == 0) && (a <= 32'd4092) && !(bus.we[w] && bus.wstrb[w] == 4'h0);
                    chk("mem_en", 32'(bus.mem_en), 32'(leg));
                    e.idx = w; e.err = !leg; e.rdata = '0;
                    if (leg) begin
                        wi = int'(a / 4);
                        chk("mem_we",   32'(bus.mem_we),   32'(bus.we[w]));
                        chk("mem_addr", 32'(bus.mem_addr), a / 4);
                        if (bus.we[w]) begin
                            chk("mem_wdata", bus.mem_wdata, bus.wdata[w]);
                            chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(bus.wstrb[w]));
                            shadow[wi] = merge(sh_rd(wi), bus.wdata[w], bus.wstrb[w]);
                        end else begin
                            e.rdata = sh_rd(wi);
                        end
                    end
                    expq.push_back(e);
                    if (!m_locked) begin
                        if (bus.lock[w]) begin m_locked = 1; m_owner = w; end
                    end else if (!bus.lock[w]) begin
                        m_locked = 0;
                    end
                    m_last = w;
                end else begin
                    chk("mem_en_idle", 32'(bus.mem_en), 32'h0);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.req = '0; bus.we = '0; bus.lock = '0;
        bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
        active[0] = 1'b0; active[1] = 1'b0;
        cur[0] = mk(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cur[1] = cur[0];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Both requesting right after reset: alternate 0,1,0,1.
        repeat (2) q0.push_back(mk(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0));
        repeat (2) q1.push_back(mk(0, 1'b0, 1'b0, 32'h14, 32'h0, 4'h0));
        run_phase();

        // Lone requester 0: same-cycle grant, back-to-back to the same port.
        q0.push_back(mk(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0));
        q0.push_back(mk(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'b0101));
        q0.push_back(mk(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0));
        run_phase();

        // Address boundaries from requester 1.
        q1.push_back(mk(0, 1'b1, 1'b0, 32'h1002, 32'h1111_1111, 4'hF));
        q1.push_back(mk(0, 1'b1, 1'b0, 32'h1000, 32'h2222_2222, 4'hF));
        q1.push_back(mk(0, 1'b1, 1'b0, 32'hFFC,  32'h3333_3333, 4'h0));
        q1.push_back(mk(0, 1'b1, 1'b0, 32'hFFC,  32'h4444_4444, 4'hF));
        q1.push_back(mk(0, 1'b0, 1'b0, 32'hFFC,  32'h0, 4'h0));
        q1.push_back(mk(0, 1'b0, 1'b0, 32'h1000, 32'h0, 4'h0));
        run_phase();

        // Requester 0 holds the lock (including an illegal locked access and an idle gap).
        q0.push_back(mk(0, 1'b1, 1'b1, 32'h20, 32'hAAAA_0001, 4'hF));
        q0.push_back(mk(0, 1'b1, 1'b1, 32'h22, 32'hAAAA_0002, 4'hF));
        q0.push_back(mk(3, 1'b1, 1'b1, 32'h24, 32'hAAAA_0003, 4'hF));
        q0.push_back(mk(0, 1'b1, 1'b0, 32'h28, 32'hAAAA_0004, 4'hF));
        q1.push_back(mk(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0));
        run_phase();

        // Reset in the cycle after a grant drops the response; first tie then goes to 0.
        q0.push_back(mk(0, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0));
        run_phase();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q0.push_back(mk(0, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0));
        q1.push_back(mk(0, 1'b0, 1'b0, 32'h24, 32'h0, 4'h0));
        run_phase();

        // Random traffic.
        for (int n = 0; n < 120; n++) begin
            q0.push_back(rand_item(n == 119));
            q1.push_back(rand_item(n == 119));
        end
        run_phase();

        repeat (3) @(posedge clk);
        chk("drained", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
